// File: rtl/abp_sender.sv
// Alternating-bit-protocol transmit engine: streams frame_len words from a
// single-port BRAM onto a valid/ready link, holding each word until acked.
module abp_sender #(
   parameter int ADDRESS_WIDTH  = 6,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH:0]   frame_len,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              retx_count,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_seq,
   input  logic                     ack_valid,
   input  logic                     ack_seq
);

   localparam int LEN_W   = ADDRESS_WIDTH + 1;
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_SEND,
      S_WAIT_ACK,
      S_DONE
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [LEN_W-1:0]        len;
   logic [LEN_W-1:0]        idx;
   logic                    seq;
   logic [DATA_WIDTH-1:0]   hold;
   logic [TIMER_W-1:0]      timer;
   logic [15:0]             retx;

   logic                    accept;
   logic                    ack_ok;
   logic                    timeout;
   logic                    last_word;

   function automatic logic [15:0] sat_inc(input logic [15:0] val);
      return (val == 16'hFFFF) ? val : val + 16'd1;
   endfunction

   // idx is one bit wider than the address so a 2**ADDRESS_WIDTH frame
   // reaches its last-word compare without wrapping
   assign last_word = (idx == len - LEN_W'(1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_ok    = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (frame_len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ:  state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_SEND;
         S_SEND: begin
            if (tx_ready) state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // a matching ack takes priority over a timeout in the same cycle
            if (ack_valid && (ack_seq == seq)) begin
               ack_ok    = 1'b1;
               state_nxt = last_word ? S_DONE : S_READ;
            end else if (timer == TIMER_LAST) begin
               timeout   = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         len   <= '0;
         idx   <= '0;
         seq   <= 1'b0;
         hold  <= '0;
         timer <= '0;
         retx  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            len  <= frame_len;
            idx  <= '0;
            retx <= '0;
         end
         if (state == S_LATCH) hold <= mem_rdata;
         if (state == S_SEND) begin
            timer <= '0;
         end else if ((state == S_WAIT_ACK) && (timer != TIMER_LAST)) begin
            timer <= timer + TIMER_W'(1);
         end
         if (ack_ok) begin
            seq <= ~seq;
            if (!last_word) idx <= idx + LEN_W'(1);
         end
         if (timeout) retx <= sat_inc(retx);
      end
   end

   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign mem_en     = (state == S_READ);
   assign mem_we     = 1'b0;
   assign mem_addr   = idx[ADDRESS_WIDTH-1:0];
   assign tx_valid   = (state == S_SEND);
   assign tx_data    = hold;
   assign tx_seq     = seq;
   assign retx_count = retx;

endmodule

// File: tb/tb_abp_sender.sv
// Directed bench for abp_sender: BRAM model, link monitor and ack responder
// around a linear sequence of frames with hand-computed expectations.
module tb_abp_sender;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   frame_len = '0;
   logic          busy;
   logic          done;
   logic [15:0]   retx_count;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          tx_valid;
   logic          tx_ready = 1'b1;
   logic [DW-1:0] tx_data;
   logic          tx_seq;
   logic          ack_valid;
   logic          ack_seq;

   logic          auto_ack = 1'b0;
   logic          auto_v = 1'b0;
   logic          auto_s = 1'b0;
   logic          man_v = 1'b0;
   logic          man_s = 1'b0;

   assign ack_valid = auto_ack ? auto_v : man_v;
   assign ack_seq   = auto_ack ? auto_s : man_s;

   abp_sender #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .busy      (busy),
      .done      (done),
      .retx_count(retx_count),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_seq    (tx_seq),
      .ack_valid (ack_valid),
      .ack_seq   (ack_seq)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [64];
   int            cyc = 0;
   logic [DW-1:0] hs_data [$];
   logic          hs_seq  [$];
   int            hs_cyc  [$];
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            rd_cnt [64];
   int            rd_total = 0;
   logic [AW-1:0] last_rd_addr = '0;
   logic          we_seen = 1'b0;
   int            total = 0;
   int            bad = 0;

   initial for (int i = 0; i < 64; i++) rd_cnt[i] = 0;

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem[mem_addr];
   end

   // event indices are the cycle number in which the condition was present
   always @(posedge clk) begin
      cyc <= cyc + 1;
      we_seen <= we_seen | mem_we;
      if (tx_valid && tx_ready) begin
         hs_data.push_back(tx_data);
         hs_seq.push_back(tx_seq);
         hs_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (mem_en) begin
         rd_cnt[mem_addr] <= rd_cnt[mem_addr] + 1;
         rd_total         <= rd_total + 1;
         last_rd_addr     <= mem_addr;
      end
   end

   // answers every accepted word one cycle later with its own sequence bit
   always @(posedge clk) begin
      logic hs;
      logic hs_s;
      hs   = tx_valid && tx_ready;
      hs_s = tx_seq;
      #1;
      auto_v = hs;
      auto_s = hs_s;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int dbase, input int budget);
      int n;
      n = 0;
      while (done_cnt == dbase && n < budget) begin
         tick();
         n++;
      end
      check("done_reached", 32'(done_cnt != dbase), 32'd1);
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n;
      n = 0;
      while (hs_data.size() < target && n < budget) begin
         tick();
         n++;
      end
      check("hs_reached", 32'(hs_data.size() >= target), 32'd1);
   endtask

   task automatic kick(input int len, output int t0);
      frame_len = (AW+1)'(len);
      start     = 1'b1;
      t0        = cyc;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      int t0;
      int base;
      int dbase;
      int rbase;
      int errs;
      int snap [64];

      for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 7);
      mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;

      repeat (3) tick();
      rst = 1'b0;
      check("rst_busy",   32'(busy),       32'd0);
      check("rst_done",   32'(done),       32'd0);
      check("rst_mem_en", 32'(mem_en),     32'd0);
      check("rst_txv",    32'(tx_valid),   32'd0);
      check("rst_txdata", 32'(tx_data),    32'd0);
      check("rst_seq",    32'(tx_seq),     32'd0);
      check("rst_retx",   32'(retx_count), 32'd0);

      // four words, immediate ack
      tx_ready = 1'b1; auto_ack = 1'b1;
      base = hs_data.size(); dbase = done_cnt;
      kick(4, t0);
      check("f1_busy_c1",  32'(busy),     32'd1);
      check("f1_memen_c1", 32'(mem_en),   32'd1);
      check("f1_addr_c1",  32'(mem_addr), 32'd0);
      wait_done(dbase, 60);
      check("f1_hs_count", 32'(hs_data.size() - base), 32'd4);
      check("f1_first_tx", 32'(hs_cyc[base] - t0), 32'd3);
      check("f1_d0", 32'(hs_data[base]),   32'hA0);
      check("f1_d1", 32'(hs_data[base+1]), 32'hA1);
      check("f1_d2", 32'(hs_data[base+2]), 32'hA2);
      check("f1_d3", 32'(hs_data[base+3]), 32'hA3);
      check("f1_s0", 32'(hs_seq[base]),    32'd0);
      check("f1_s1", 32'(hs_seq[base+1]),  32'd1);
      check("f1_s2", 32'(hs_seq[base+2]),  32'd0);
      check("f1_s3", 32'(hs_seq[base+3]),  32'd1);
      check("f1_done_cyc", 32'(done_cyc - t0), 32'd17);
      check("f1_busy_after", 32'(busy), 32'd0);
      check("f1_retx", 32'(retx_count), 32'd0);

      // first ack withheld: word 0 resent after the timeout
      auto_ack = 1'b0;
      base = hs_data.size(); dbase = done_cnt;
      kick(2, t0);
      wait_hs(base + 2, 40);
      auto_ack = 1'b1;
      wait_done(dbase, 40);
      check("f2_gap",   32'(hs_cyc[base+1] - hs_cyc[base]), 32'd9);
      check("f2_rd0",   32'(hs_data[base+1]), 32'hA0);
      check("f2_rs0",   32'(hs_seq[base+1]),  32'd0);
      check("f2_d1",    32'(hs_data[base+2]), 32'hA1);
      check("f2_s1",    32'(hs_seq[base+2]),  32'd1);
      check("f2_retx",  32'(retx_count), 32'd1);

      // stalled link for 5 cycles, then stale acks, then timeout retransmit
      auto_ack = 1'b0; tx_ready = 1'b0;
      mem[0] = 8'hC0; mem[1] = 8'hC1;
      base = hs_data.size(); dbase = done_cnt;
      kick(2, t0);
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         check("f3_stall_v", 32'(tx_valid), 32'd1);
         check("f3_stall_d", 32'(tx_data),  32'hC0);
         check("f3_stall_s", 32'(tx_seq),   32'd0);
      end
      tick();
      tx_ready = 1'b1;
      tick();
      man_v = 1'b1; man_s = 1'b1;
      repeat (3) tick();
      man_v = 1'b0;
      wait_hs(base + 2, 40);
      auto_ack = 1'b1;
      wait_done(dbase, 40);
      check("f3_acc_cyc", 32'(hs_cyc[base] - t0),   32'd8);
      check("f3_re_cyc",  32'(hs_cyc[base+1] - t0), 32'd17);
      check("f3_rd",      32'(hs_data[base+1]), 32'hC0);
      check("f3_rs",      32'(hs_seq[base+1]),  32'd0);
      check("f3_d1",      32'(hs_data[base+2]), 32'hC1);
      check("f3_s1",      32'(hs_seq[base+2]),  32'd1);
      check("f3_retx",    32'(retx_count), 32'd1);

      // empty frame
      rbase = rd_total; dbase = done_cnt;
      kick(0, t0);
      check("f4_done_c1", 32'(done), 32'd1);
      tick();
      check("f4_busy_c2", 32'(busy), 32'd0);
      check("f4_no_read", 32'(rd_total - rbase), 32'd0);
      check("f4_done_n",  32'(done_cnt - dbase), 32'd1);

      // full 64-word frame
      for (int i = 0; i < 64; i++) begin
         mem[i] = 8'(i * 5 + 1);
         snap[i] = rd_cnt[i];
      end
      base = hs_data.size(); dbase = done_cnt;
      kick(64, t0);
      wait_done(dbase, 400);
      errs = 0;
      for (int i = 0; i < 64; i++) if (rd_cnt[i] - snap[i] != 1) errs++;
      check("f5_addr_once", 32'(errs), 32'd0);
      check("f5_hs_count",  32'(hs_data.size() - base), 32'd64);
      errs = 0;
      for (int i = 0; i < 64; i++) begin
         if (hs_data[base+i] !== 8'(i * 5 + 1)) errs++;
         if (hs_seq[base+i] !== 1'(i)) errs++;
      end
      check("f5_data_seq", 32'(errs), 32'd0);
      check("f5_last_addr", 32'(last_rd_addr), 32'd63);

      // one-word frame leaves seq at 1 ahead of the reset test
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      dbase = done_cnt;
      kick(1, t0);
      wait_done(dbase, 20);

      // reset during WAIT_ACK of word 2
      auto_ack = 1'b0;
      base = hs_data.size();
      kick(4, t0);
      for (int w = 0; w < 2; w++) begin
         wait_hs(base + w + 1, 20);
         man_v = 1'b1; man_s = hs_seq[base+w];
         tick();
         man_v = 1'b0;
      end
      wait_hs(base + 3, 20);
      check("f6_seq_w2", 32'(hs_seq[base+2]), 32'd1);
      rst = 1'b1;
      tick();
      check("f6_busy", 32'(busy),     32'd0);
      check("f6_done", 32'(done),     32'd0);
      check("f6_txv",  32'(tx_valid), 32'd0);
      check("f6_txd",  32'(tx_data),  32'd0);
      check("f6_seq",  32'(tx_seq),   32'd0);
      check("f6_memen", 32'(mem_en),  32'd0);
      rst = 1'b0;
      rbase = rd_total; dbase = done_cnt; base = hs_data.size();
      repeat (5) tick();
      check("f6_quiet", 32'((rd_total - rbase) + (done_cnt - dbase) + (hs_data.size() - base)), 32'd0);
      auto_ack = 1'b1;
      kick(1, t0);
      wait_done(dbase, 20);
      check("f6_restart_addr", 32'(last_rd_addr), 32'd0);
      check("f6_restart_reads", 32'(rd_total - rbase), 32'd1);
      check("f6_restart_seq", 32'(hs_seq[base]), 32'd0);
      check("f6_restart_data", 32'(hs_data[base]), 32'h11);

      check("mem_we_never", 32'(we_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
